// File: rtl/pipeline_processor_pkg.sv
// Shared opcodes, instruction field positions and stage bundles
// for the 4-stage ADD/SUB/LOAD pipeline.
package pipeline_processor_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_LOAD = 6'b000010;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } if_id_t;

  // fwd_a/fwd_b select the EX/WB value for the operand in EX
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] imm;
    logic        fwd_a;
    logic        fwd_b;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] value;
  } ex_wb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Read-only data memory contents: word i holds 0x100 + i
  function automatic logic [31:0] dmem_word(
    input logic [31:0] addr,
    input int unsigned depth
  );
    logic [31:0] idx;
    idx = addr & (depth - 1);
    return 32'h100 + idx;
  endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// 2R1W register file, r0 hardwired to zero, write-first bypass,
// asynchronous reset loads R[i] = i.
module pipeline_regfile
  import pipeline_processor_pkg::*;
#(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [REG_COUNT];
  logic [31:0] regs_d [REG_COUNT];

  always_comb begin
    regs_d = regs_q;
    if (we && wa != 5'd0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        regs_q[i] <= 32'(i);
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_a = regs_q[ra_a];
    rd_b = regs_q[ra_b];
    if (we && wa == ra_a) rd_a = wd;
    if (we && wa == ra_b) rd_b = wd;
    if (ra_a == 5'd0) rd_a = '0;
    if (ra_b == 5'd0) rd_b = '0;
  end

endmodule

// File: rtl/pipeline_processor.sv
// IF/ID/EX/WB datapath executing ADD, SUB and LOAD.
// Define PIPE_FWD_EN to enable EX/WB -> EX operand forwarding.
module pipeline_processor
  import pipeline_processor_pkg::*;
#(
  parameter int REG_COUNT  = 32,
  parameter int DMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] result
);

  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_wb_t      ex_wb_q, ex_wb_d;
  logic [31:0] result_q, result_d;

  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_known;
  logic [31:0] rf_a, rf_b;
  logic [31:0] ex_a, ex_b, ex_val;

  pipeline_regfile #(
    .REG_COUNT(REG_COUNT)
  ) u_rf (
    .clk  (clk),
    .rst_n(reset),
    .ra_a (id_rs),
    .ra_b (id_rt),
    .rd_a (rf_a),
    .rd_b (rf_b),
    .we   (ex_wb_q.valid),
    .wa   (ex_wb_q.dest),
    .wd   (ex_wb_q.value)
  );

  always_comb begin
    if_id_d.valid = 1'b1;
    if_id_d.instr = instruction;
  end

  always_comb begin
    id_op = if_id_q.instr[OP_HI:OP_LO];
    id_rs = if_id_q.instr[RS_HI:RS_LO];
    id_rt = if_id_q.instr[RT_HI:RT_LO];
    id_rd = if_id_q.instr[RD_HI:RD_LO];
    id_known = (id_op == OP_ADD) ||
               (id_op == OP_SUB) ||
               (id_op == OP_LOAD);
    id_ex_d       = '0;
    id_ex_d.valid = if_id_q.valid && id_known;
    id_ex_d.op    = id_op;
    id_ex_d.dest  = (id_op == OP_LOAD) ? id_rt : id_rd;
    id_ex_d.opa   = rf_a;
    id_ex_d.opb   = rf_b;
    id_ex_d.imm   = sext16(if_id_q.instr[IMM_HI:IMM_LO]);
`ifdef PIPE_FWD_EN
    // Current ID/EX occupant will sit in EX/WB when this one reaches EX
    id_ex_d.fwd_a = id_ex_q.valid && id_ex_q.dest != 5'd0 &&
                    id_ex_q.dest == id_rs;
    id_ex_d.fwd_b = id_ex_q.valid && id_ex_q.dest != 5'd0 &&
                    id_ex_q.dest == id_rt;
`else
    id_ex_d.fwd_a = 1'b0;
    id_ex_d.fwd_b = 1'b0;
`endif
  end

  always_comb begin
    ex_a = id_ex_q.fwd_a ? ex_wb_q.value : id_ex_q.opa;
    ex_b = id_ex_q.fwd_b ? ex_wb_q.value : id_ex_q.opb;
    unique case (1'b1)
      (id_ex_q.op == OP_ADD): ex_val = ex_a + ex_b;
      (id_ex_q.op == OP_SUB): ex_val = ex_a - ex_b;
      default:
        ex_val = dmem_word(ex_a + id_ex_q.imm, DMEM_DEPTH);
    endcase
    ex_wb_d.valid = id_ex_q.valid;
    ex_wb_d.dest  = id_ex_q.dest;
    ex_wb_d.value = ex_val;
  end

  always_comb begin
    result_d = result_q;
    if (ex_wb_q.valid) result_d = ex_wb_q.value;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_wb_q  <= '0;
      result_q <= '0;
    end else begin
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_wb_q  <= ex_wb_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_pipeline_processor.sv
// Self-checking bench for pipeline_processor against an
// instruction-level reference model.
module tb_pipeline_processor;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = NOP;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_prev [32];
  logic [31:0] m_res;
  logic [31:0] exp_q [$];

  pipeline_processor dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .result     (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'(i);
    m_prev = m_reg;
    m_res = '0;
    exp_q = {};
    repeat (3) exp_q.push_back(32'd0);
  endtask

  // Without forwarding an instruction sees the register file as it was
  // two instructions back; with forwarding it sees the latest state.
  task automatic model_issue(input logic [31:0] ins);
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, v, sx;
    bit          ok;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sx = {{16{ins[15]}}, ins[15:0]};
    if (FWD) begin a = m_reg[rs];  b = m_reg[rt];  end
    else     begin a = m_prev[rs]; b = m_prev[rt]; end
    ok = 1'b1; dst = rd; v = '0;
    case (op)
      6'd0: v = a + b;
      6'd1: v = a - b;
      6'd2: begin v = 32'h100 + ((a + sx) % 32'd16); dst = rt; end
      default: ok = 1'b0;
    endcase
    m_prev = m_reg;
    if (ok && dst != 5'd0) m_reg[dst] = v;
    if (ok) m_res = v;
    exp_q.push_back(m_res);
  endtask

  task automatic step(input logic [31:0] ins,
                      output logic [31:0] obs, output logic [31:0] exp);
    instruction = ins;
    @(posedge clk);
    model_issue(ins);
    #1;
    exp = exp_q.pop_front();
    obs = result;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    instruction = enc_r(6'd0, 5'd5, 5'd6, 5'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_seq(input string nm, input logic [31:0] seq [$],
                         output logic [31:0] obs [$]);
    logic [31:0] o, e;
    obs = {};
    foreach (seq[i]) begin
      step(seq[i], o, e);
      obs.push_back(o);
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s[%0d]: result=%h expected=%h", nm, i, o, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instruction = enc_r(6'd0, 5'd5, 5'd6, 5'd1);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_hold: result=%h expected=%h", result, 32'd0);
    end
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [31:0] obs [$];
    run_seq("add", '{enc_r(6'd0, 5'd5, 5'd6, 5'd1), NOP, NOP, NOP}, obs);
    n_cmp++;
    if (obs[3] !== 32'd11) begin
      n_bad++;
      $display("FAIL add_lat: result=%h expected=%h", obs[3], 32'd11);
    end
  endtask

  task automatic test_sub();
    logic [31:0] obs [$];
    run_seq("sub", '{32'h04E8_1022, NOP, NOP, NOP}, obs);
    n_cmp++;
    if (obs[3] !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sub_wrap: result=%h expected=%h", obs[3], 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_load();
    logic [31:0] obs [$];
    run_seq("load", '{32'h0923_0010, NOP, NOP, NOP}, obs);
    n_cmp++;
    if (obs[3] !== 32'h0000_0109) begin
      n_bad++;
      $display("FAIL load_wrap: result=%h expected=%h", obs[3], 32'h109);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] obs [$];
    logic [31:0] want;
    do_reset();
    run_seq("hazard", '{enc_r(6'd0, 5'd5, 5'd6, 5'd1),
                        enc_r(6'd0, 5'd1, 5'd1, 5'd4), NOP, NOP, NOP}, obs);
    want = FWD ? 32'd22 : 32'd2;
    n_cmp++;
    if (obs[3] !== 32'd11 || obs[4] !== want) begin
      n_bad++;
      $display("FAIL hazard: results=%h,%h expected=%h,%h",
               obs[3], obs[4], 32'd11, want);
    end
  endtask

  task automatic test_nop();
    logic [31:0] obs [$];
    run_seq("nop", '{enc_r(6'd0, 5'd5, 5'd6, 5'd1), NOP,
                     enc_r(6'd0, 5'd7, 5'd7, 5'd2), NOP, NOP, NOP}, obs);
    n_cmp++;
    if (obs[3] !== 32'd11 || obs[4] !== 32'd11 || obs[5] !== 32'd14) begin
      n_bad++;
      $display("FAIL nop_hold: results=%h,%h,%h expected=b,b,e",
               obs[3], obs[4], obs[5]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs [$];
    logic [31:0] o, e;
    step(enc_r(6'd0, 5'd5, 5'd6, 5'd1), o, e);
    step(NOP, o, e);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_async: result=%h expected=%h", result, 32'd0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_seq("reset_mid", '{enc_r(6'd0, 5'd1, 5'd0, 5'd4), NOP, NOP, NOP}, obs);
    n_cmp++;
    if (obs[3] !== 32'd1) begin
      n_bad++;
      $display("FAIL reset_discard: result=%h expected=%h", obs[3], 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [$];
    logic [31:0] obs [$];
    do_reset();
    for (int i = 0; i < 6; i++) seq.push_back(enc_r(6'd0, 5'd1, 5'd1, 5'd1));
    seq.push_back(enc_r(6'd1, 5'd1, 5'd2, 5'd3));
    repeat (3) seq.push_back(NOP);
    run_seq("b2b", seq, obs);
  endtask

  task automatic test_random();
    logic [31:0] seq [$];
    logic [31:0] obs [$];
    logic [5:0]  op;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: op = 6'd0;
        1: op = 6'd1;
        2: op = 6'd2;
        3: op = 6'd0;
        default: op = 6'($urandom_range(3, 63));
      endcase
      seq.push_back({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 11'($urandom)});
    end
    repeat (3) seq.push_back(NOP);
    run_seq("random", seq, obs);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_load();
    test_hazard();
    test_nop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
